// File: rtl/ram_arbiter_if.sv
// Per-master request/response bundle for ram_arbiter. The master modport drives the request.
// The slave modport is the arbiter side and returns rdata/ack/err.
interface ram_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for the 16-bit single-port ram, with a REQ/WAIT watchdog.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; the default is fixed priority with m0 first.
module ram_arbiter #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      m0,
    ram_arbiter_if.slave      m1,
    output logic              ram_cs,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    input  logic              ram_ready,
    output logic              grant,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]        state;
    logic              rdy_seen;
    logic              done_pend;
    logic [CNT_W-1:0]  cnt;
    logic              tmo_hit;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;

    logic              win;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef RAM_ARB_RR_EN
    logic              last_grant;
`endif

    assign any_req = m0.req | m1.req;
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign busy    = (state != ST_IDLE);

    always_comb begin
        win = 1'b0;
        if (m0.req && m1.req) begin
`ifdef RAM_ARB_RR_EN
            win = ~last_grant;
`else
            win = 1'b0;
`endif
        end else if (m1.req) begin
            win = 1'b1;
        end
    end

    always_comb begin
        sel_we    = win ? m1.we    : m0.we;
        sel_addr  = win ? m1.addr  : m0.addr;
        sel_wdata = win ? m1.wdata : m0.wdata;
    end

    // Block only drives the bus for an active write; reads, INIT and IDLE leave it to the ram.
    assign ram_data = (ram_cs && !ram_read) ? wdata_q : 'z;

    assign m0.rdata = rdata0_q;
    assign m1.rdata = rdata1_q;
    assign m0.ack   = ack_q[0];
    assign m1.ack   = ack_q[1];
    assign m0.err   = err_q[0];
    assign m1.err   = err_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            rdy_seen  <= 1'b0;
            done_pend <= 1'b0;
            cnt       <= '0;
            ram_cs    <= 1'b0;
            ram_read  <= 1'b1;
            ram_addr  <= '0;
            wdata_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            grant     <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            ack_q <= '0;
            err_q <= '0;

            // Ack is issued one cycle after completion; IDLE holds off arbitration until then
            // so a master still holding its finished request is not granted twice.
            if (done_pend) begin
                ack_q[grant] <= 1'b1;
                done_pend    <= 1'b0;
            end

            case (state)
                ST_INIT: begin
                    if (ram_ready) begin
                        rdy_seen <= ~rdy_seen;
                        if (rdy_seen) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        rdy_seen <= 1'b0;
                    end
                end

                ST_IDLE: begin
                    if (any_req && !done_pend) begin
                        grant    <= win;
`ifdef RAM_ARB_RR_EN
                        last_grant <= win;
`endif
                        ram_cs   <= 1'b1;
                        ram_read <= ~sel_we;
                        ram_addr <= sel_addr;
                        wdata_q  <= sel_wdata;
                        cnt      <= '0;
                        state    <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (tmo_hit) begin
                        ram_cs       <= 1'b0;
                        ram_read     <= 1'b1;
                        err_q[grant] <= 1'b1;
                        rdy_seen     <= 1'b0;
                        state        <= ST_INIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!ram_ready) begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (ram_ready) begin
                        ram_cs   <= 1'b0;
                        ram_read <= 1'b1;
                        if (ram_read) begin
                            if (grant) begin
                                rdata1_q <= ram_data;
                            end else begin
                                rdata0_q <= ram_data;
                            end
                        end
                        done_pend <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (tmo_hit) begin
                        ram_cs       <= 1'b0;
                        ram_read     <= 1'b1;
                        err_q[grant] <= 1'b1;
                        rdy_seen     <= 1'b0;
                        state        <= ST_INIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port ram (cs/read/ready protocol).
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m0_if ();
    ram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) m1_if ();

    logic              ram_cs;
    logic              ram_read;
    logic [ADDR_W-1:0] ram_addr;
    wire  [DATA_W-1:0] ram_data;
    logic              ram_ready;
    logic              grant;
    logic              busy;

    ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0        (m0_if),
        .m1        (m1_if),
        .ram_cs    (ram_cs),
        .ram_read  (ram_read),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_ready (ram_ready),
        .grant     (grant),
        .busy      (busy)
    );

    // Ram model: accepts an access when it sees cs with ready high, goes busy for ram_wait
    // cycles, and will not restart until cs has been seen low again.
    logic [DATA_W-1:0] mem [0:16383];
    logic [DATA_W-1:0] ram_q = '0;
    logic              ram_rdy_q = 1'b1;
    logic              ram_done = 1'b0;
    int unsigned       ram_bcnt = 0;
    int unsigned       ram_wait = 1;
    bit                ram_stuck = 1'b0;

    assign ram_ready = ram_stuck ? 1'b1 : ram_rdy_q;
    assign ram_data  = (ram_cs && ram_read && !ram_stuck) ? ram_q : 'z;

    always @(posedge clk) begin
        if (!ram_cs) ram_done <= 1'b0;
        if (!ram_stuck) begin
            if (ram_rdy_q) begin
                if (ram_cs && !ram_done) begin
                    ram_rdy_q <= 1'b0;
                    ram_bcnt  <= ram_wait;
                    if (ram_read) ram_q <= mem[ram_addr[13:0]];
                    else          mem[ram_addr[13:0]] <= ram_data;
                end
            end else if (ram_bcnt <= 1) begin
                ram_rdy_q <= 1'b1;
                ram_done  <= 1'b1;
            end else begin
                ram_bcnt <= ram_bcnt - 1;
            end
        end
    end

    int unsigned       checks = 0;
    int unsigned       errors = 0;
    logic [DATA_W-1:0] exp_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Continuous protocol checks on DUT events
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_if.ack || m0_if.err || m1_if.ack || m1_if.err) begin
                check("ack_err_excl", {31'b0, (m0_if.ack & m0_if.err) | (m1_if.ack & m1_if.err)}, 0);
                check("cs_low_at_ack", {31'b0, ram_cs}, 0);
            end
            if (ram_cs && ram_read && !ram_stuck) check("rd_bus_undriven", {16'b0, ram_data}, {16'b0, ram_q});
            if (ram_cs && !ram_read) check("wr_bus_data", {16'b0, ram_data}, {16'b0, exp_wdata});
        end
    end

    task automatic do_xfer(input bit m, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                           output logic [15:0] rd, output int cyc, output bit acked, output bit erred);
        exp_wdata = wd;
        if (!m) begin
            m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wd; m0_if.req = 1'b1;
        end else begin
            m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wd; m1_if.req = 1'b1;
        end
        cyc = 0; acked = 1'b0; erred = 1'b0;
        while (!acked && !erred && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            acked = m ? m1_if.ack : m0_if.ack;
            erred = m ? m1_if.err : m0_if.err;
        end
        rd = m ? m1_if.rdata : m0_if.rdata;
        if (!m) m0_if.req = 1'b0; else m1_if.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          cyc;
        bit          acked, erred;
        int          nacks, n1, n;
        bit          winner, exp_w;

        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cs", {31'b0, ram_cs}, 0);
        check("rst_read", {31'b0, ram_read}, 1);
        check("rst_addr", {16'b0, ram_addr}, 0);
        check("rst_busy", {31'b0, busy}, 1);
        check("rst_grant", {31'b0, grant}, 0);
        check("rst_acks", {28'b0, m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 0);
        check("rst_rdata", {m1_if.rdata, m0_if.rdata}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("init_first_edge_busy", {31'b0, busy}, 1);
        @(posedge clk); #1;
        check("init_idle_busy", {31'b0, busy}, 0);

        // Both masters requesting reads continuously, 8 transfers
        m0_if.we = 1'b0; m0_if.addr = 16'h0100;
        m1_if.we = 1'b0; m1_if.addr = 16'h0200;
        exp_wdata = '0;
        m0_if.req = 1'b1; m1_if.req = 1'b1;
        nacks = 0; n1 = 0; n = 0;
        while (nacks < 8 && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (m0_if.ack || m1_if.ack) begin
                winner = m1_if.ack;
`ifdef RAM_ARB_RR_EN
                exp_w = nacks[0];
`else
                exp_w = 1'b0;
`endif
                check("arb_winner", {31'b0, winner}, {31'b0, exp_w});
                check("arb_grant", {31'b0, grant}, {31'b0, exp_w});
                if (winner) n1++;
                nacks++;
            end
        end
        m0_if.req = 1'b0; m1_if.req = 1'b0;
        check("arb_count", nacks, 8);
`ifdef RAM_ARB_RR_EN
        check("arb_m1_share", n1, 4);
`else
        check("arb_m1_starved", n1, 0);
`endif
        repeat (3) @(posedge clk);
        #1;

        // m0 write then read back, back-to-back
        do_xfer(1'b0, 1'b1, 16'h0010, 16'hA5A5, rd, cyc, acked, erred);
        check("wr_ack", {31'b0, acked}, 1);
        check("wr_no_err", {31'b0, erred}, 0);
        check("wr_latency", cyc, 5);
        check("wr_mem", {16'b0, mem[14'h0010]}, 16'hA5A5);
        do_xfer(1'b0, 1'b0, 16'h0010, 16'h0000, rd, cyc, acked, erred);
        check("rd_ack", {31'b0, acked}, 1);
        check("rd_latency", cyc, 5);
        check("rd_data", {16'b0, rd}, 16'hA5A5);

        // Address aliasing on addr[13:0]
        do_xfer(1'b1, 1'b1, 16'h3FFF, 16'h1234, rd, cyc, acked, erred);
        check("alias_wr_ack", {31'b0, acked}, 1);
        check("alias_wr_grant", {31'b0, grant}, 1);
        do_xfer(1'b0, 1'b0, 16'hFFFF, 16'h0000, rd, cyc, acked, erred);
        check("alias_rd_ack", {31'b0, acked}, 1);
        check("alias_rd_data", {16'b0, rd}, 16'h1234);
        check("alias_rd_grant", {31'b0, grant}, 0);

        // Ram never responds: watchdog abort
        ram_stuck = 1'b1;
        do_xfer(1'b0, 1'b0, 16'h0010, 16'h0000, rd, cyc, acked, erred);
        check("tmo_err", {31'b0, erred}, 1);
        check("tmo_no_ack", {31'b0, acked}, 0);
        check("tmo_edges", cyc, TIMEOUT + 1);
        check("tmo_cs_low", {31'b0, ram_cs}, 0);
        check("tmo_busy_init", {31'b0, busy}, 1);
        check("tmo_rdata_kept", {16'b0, rd}, 16'h1234);
        ram_stuck = 1'b0;
        @(posedge clk); #1;
        check("tmo_init_hold", {31'b0, busy}, 1);
        @(posedge clk); #1;
        check("tmo_back_idle", {31'b0, busy}, 0);

        // Reset asserted while the transfer sits in WAIT
        ram_wait = 4;
        exp_wdata = '0;
        m0_if.we = 1'b0; m0_if.addr = 16'h0010; m0_if.req = 1'b1;
        n = 0;
        while (ram_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstw_ram_busy_seen", {31'b0, ram_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstw_cs_async", {31'b0, ram_cs}, 0);
        check("rstw_busy", {31'b0, busy}, 1);
        m0_if.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstw_no_ack_err", {30'b0, m0_if.ack | m1_if.ack, m0_if.err | m1_if.err}, 0);
        end
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstw_init_len", n, 2);
        check("rstw_no_ack_after", {31'b0, m0_if.ack}, 0);
        ram_wait = 1;
        do_xfer(1'b0, 1'b0, 16'h0010, 16'h0000, rd, cyc, acked, erred);
        check("rstw_rd_ack", {31'b0, acked}, 1);
        check("rstw_rd_data", {16'b0, rd}, 16'hA5A5);
        check("rstw_rd_latency", cyc, 5);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
